i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_FREQ, default 40_000_000, system clock frequency in Hz.
REQ-002 Parameter SCL_FREQ, default 400_000, SCL frequency in Hz; QUARTER = CLK_FREQ/(4*SCL_FREQ) clock cycles, minimum 2.
REQ-003 clk_i  input  1  system clock; the block uses one clock, and reset is synchronous and active-low.
REQ-004 rst_n_i  input  1  synchronous active-low reset.
REQ-005 cmd_valid_i  input  1  command request.
REQ-006 cmd_ready_o  output  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-007 cmd_i  input  3  0=START, 1=RSTART, 2=WRITE, 3=READ, 4=STOP; other values are illegal.
REQ-008 wr_data_i  input  8  byte for WRITE, sampled at acceptance.
REQ-009 rd_ack_i  input  1  for READ: 1=master ACKs (drives SDA low), 0=NACK; sampled at acceptance.
REQ-010 done_o  output  1  one-cycle pulse at command completion.
REQ-011 rd_data_o  output  8  received byte, valid with done_o after READ, held until the next READ completes.
REQ-012 nack_o  output  1  slave ACK bit after WRITE (1=NACK), valid with done_o.
REQ-013 err_o  output  1  pulse with done_o for an illegal or out-of-sequence command.
REQ-014 busy_o  output  1  high while the bus is owned (START through STOP completion).
REQ-015 sda_o, scl_o  output  1 each  tied 0 (open-drain data value).
REQ-016 sda_oe, scl_oe  output  1 each  1=pull line low, 0=release.
REQ-017 sda_i, scl_i  input  1 each  sampled bus levels.

Function
REQ-018 A quarter tick SHALL occur every QUARTER cycles while a command executes; each bit SHALL span 4 quarters: Q0 SCL low with SDA set, Q1 SCL released, Q2 SCL high with sampling, Q3 SCL low.
REQ-019 States SHALL be IDLE, START, RSTART, WRITE_BIT, WRITE_ACK, READ_BIT, READ_ACK, STOP, HOLD; cmd_ready_o is 1 only in IDLE and HOLD.
REQ-020 START (legal only in IDLE): SDA released for Q0-Q1, SDA low at Q2 with SCL high, SCL low at Q3, then HOLD.
REQ-021 RSTART (legal only in HOLD): release SDA at Q0, release SCL at Q1, SDA low at Q2, SCL low at Q3, then HOLD.
REQ-022 WRITE (legal only in HOLD): 8 bits MSB first, driven at Q0; then a 9th bit with SDA released and nack_o = sda_i sampled at Q2 of that bit; then HOLD.
REQ-023 READ (legal only in HOLD): SDA released, 8 bits MSB first sampled at Q2; in the 9th bit SDA is driven low if rd_ack_i=1, otherwise released; then HOLD.
REQ-024 STOP (legal only in HOLD): SDA low at Q0, SCL released at Q1, SDA released at Q2, idle at Q3, then IDLE with busy_o=0.
REQ-025 In HOLD, SCL SHALL be held low and SDA SHALL keep its last driven value.
REQ-026 An illegal command SHALL produce done_o=err_o=1 one cycle after acceptance, with no bus change and no state change.
REQ-027 Clock stretching: while SCL is released and scl_i=0, the quarter counter SHALL freeze.
REQ-028 done_o SHALL pulse on the cycle after the final Q3 tick; a new command may be accepted on the same cycle.

Reset
REQ-029 On reset: state=IDLE, sda_oe=scl_oe=0, cmd_ready_o=1, done_o=err_o=nack_o=busy_o=0, rd_data_o=0, and the counters are cleared.
REQ-030 Reset mid-transfer SHALL release both lines immediately, with no STOP generated.

Structure
REQ-031 Package i2c_master_pkg SHALL hold the command enum, the state enum, and the quarter-phase constants.
REQ-032 Sub-module i2c_quarter_tick SHALL generate the quarter tick, with enable and stretch-freeze inputs.

Verification
REQ-033 CLK_FREQ=40 MHz, SCL_FREQ=400 kHz: START -> SDA falls while SCL is high; SCL falls 25 cycles later; done_o pulses.
REQ-034 START, WRITE 0x72 with no slave (pull-ups only) -> SDA shows 0,1,1,1,0,0,1,0 at SCL rising edges; nack_o=1; each bit lasts 100 cycles.
REQ-035 RSTART, WRITE 0xA4, STOP -> repeated start is seen with SCL high; bits 1,0,1,0,0,1,0,0; SDA rises while SCL is high; busy_o=0.
REQ-036 A slave model returning 0x5A with READ rd_ack_i=0 -> rd_data_o=0x5A and SDA is released in the 9th bit.
REQ-037 WRITE issued in IDLE -> done_o=err_o=1 and both lines stay released.
REQ-038 A slave holding SCL low for 500 cycles during WRITE -> the bit timing extends by 500 cycles and the data is unchanged.

Source files
------------

// File: rtl/i2c_master_pkg.sv
// Shared types for the I2C byte-level master: command codes, FSM states,
// quarter-phase encoding and the per-quarter open-drain drive table.
package i2c_master_pkg;

    typedef enum logic [2:0] {
        CMD_START  = 3'd0,
        CMD_RSTART = 3'd1,
        CMD_WRITE  = 3'd2,
        CMD_READ   = 3'd3,
        CMD_STOP   = 3'd4
    } cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_RSTART,
        ST_WRITE_BIT,
        ST_WRITE_ACK,
        ST_READ_BIT,
        ST_READ_ACK,
        ST_STOP,
        ST_HOLD
    } state_e;

    localparam logic [1:0] PH_Q0 = 2'd0;
    localparam logic [1:0] PH_Q1 = 2'd1;
    localparam logic [1:0] PH_Q2 = 2'd2;
    localparam logic [1:0] PH_Q3 = 2'd3;

    typedef struct packed {
        logic scl_oe;
        logic sda_oe;
    } drive_t;

    // Line drive on entry to quarter ph of state st; unlisted cases keep the current drive.
    function automatic drive_t phase_drive(input state_e     st,
                                           input logic [1:0] ph,
                                           input logic       tx_bit,
                                           input logic       rd_ack,
                                           input drive_t     cur);
        drive_t d;
        d = cur;
        case (st)
            ST_START: begin
                case (ph)
                    PH_Q0:   begin d.scl_oe = 1'b0; d.sda_oe = 1'b0; end
                    PH_Q2:   d.sda_oe = 1'b1;
                    PH_Q3:   d.scl_oe = 1'b1;
                    default: ;
                endcase
            end
            ST_RSTART: begin
                case (ph)
                    PH_Q0:   d.sda_oe = 1'b0;
                    PH_Q1:   d.scl_oe = 1'b0;
                    PH_Q2:   d.sda_oe = 1'b1;
                    default: d.scl_oe = 1'b1;
                endcase
            end
            ST_STOP: begin
                case (ph)
                    PH_Q0:   begin d.scl_oe = 1'b1; d.sda_oe = 1'b1; end
                    PH_Q1:   d.scl_oe = 1'b0;
                    PH_Q2:   d.sda_oe = 1'b0;
                    default: ;
                endcase
            end
            ST_WRITE_BIT, ST_WRITE_ACK, ST_READ_BIT, ST_READ_ACK: begin
                case (ph)
                    PH_Q0: begin
                        d.scl_oe = 1'b1;
                        case (st)
                            ST_WRITE_BIT: d.sda_oe = ~tx_bit;
                            ST_READ_ACK:  d.sda_oe = rd_ack;
                            default:      d.sda_oe = 1'b0;
                        endcase
                    end
                    PH_Q1:   d.scl_oe = 1'b0;
                    PH_Q3:   d.scl_oe = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: pulses tick_o every QUARTER enabled cycles and
// freezes while a slave stretches SCL.
module i2c_quarter_tick #(
    parameter int QUARTER = 25
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic freeze_i,
    output logic tick_o
);
    localparam int CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;
    localparam logic [CW-1:0] LAST = CW'(QUARTER - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = en_i && !freeze_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en_i) begin
            cnt_d = '0;
        end else if (!freeze_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// Byte-level I2C master: executes START/RSTART/WRITE/READ/STOP commands one at
// a time, each bit built from four quarter periods, with clock-stretch support.
module i2c_master
    import i2c_master_pkg::*;
#(
    parameter int CLK_FREQ = 40_000_000,
    parameter int SCL_FREQ = 400_000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic [2:0] cmd_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_ack_i,
    output logic       done_o,
    output logic [7:0] rd_data_o,
    output logic       nack_o,
    output logic       err_o,
    output logic       busy_o,
    output logic       sda_o,
    output logic       scl_o,
    output logic       sda_oe,
    output logic       scl_oe,
    input  logic       sda_i,
    input  logic       scl_i
);
    localparam int QUARTER_CALC = CLK_FREQ / (4 * SCL_FREQ);
    localparam int QUARTER      = (QUARTER_CALC < 2) ? 2 : QUARTER_CALC;

    state_e     state_q, state_d;
    logic [1:0] phase_q, phase_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       rd_ack_q, rd_ack_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       nack_q, nack_d;
    logic       done_q, done_d;
    logic       err_q, err_d;
    drive_t     drive_q, drive_d;

    logic       ready;
    logic       accept;
    logic       tick;
    logic       freeze;
    logic       load_drive;
    logic       cmd_legal;
    state_e     cmd_state;

    assign ready  = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign accept = cmd_valid_i && ready;
    // sda_i/scl_i are expected already synchronised; a synchroniser here would stall every SCL release.
    assign freeze = !drive_q.scl_oe && !scl_i;

    i2c_quarter_tick #(.QUARTER(QUARTER)) u_tick (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (!ready),
        .freeze_i (freeze),
        .tick_o   (tick)
    );

    always_comb begin
        cmd_legal = 1'b0;
        cmd_state = ST_IDLE;
        case (cmd_e'(cmd_i))
            CMD_START:  begin cmd_legal = (state_q == ST_IDLE); cmd_state = ST_START;     end
            CMD_RSTART: begin cmd_legal = (state_q == ST_HOLD); cmd_state = ST_RSTART;    end
            CMD_WRITE:  begin cmd_legal = (state_q == ST_HOLD); cmd_state = ST_WRITE_BIT; end
            CMD_READ:   begin cmd_legal = (state_q == ST_HOLD); cmd_state = ST_READ_BIT;  end
            CMD_STOP:   begin cmd_legal = (state_q == ST_HOLD); cmd_state = ST_STOP;      end
            default:    ;
        endcase
    end

    // NOTE: every signal written below gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        rd_ack_d   = rd_ack_q;
        rd_data_d  = rd_data_q;
        nack_d     = nack_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        drive_d    = drive_q;
        load_drive = 1'b0;

        if (ready) begin
            if (accept) begin
                if (cmd_legal) begin
                    state_d    = cmd_state;
                    phase_d    = PH_Q0;
                    bit_cnt_d  = 3'd0;
                    shift_d    = wr_data_i;
                    rd_ack_d   = rd_ack_i;
                    load_drive = 1'b1;
                end else begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                end
            end
        end else if (tick) begin
            phase_d    = phase_q + 2'd1;
            load_drive = 1'b1;
            if (phase_q == PH_Q2) begin
                if (state_q == ST_READ_BIT) shift_d = {shift_q[6:0], sda_i};
                if (state_q == ST_WRITE_ACK) nack_d = sda_i;
            end
            if (phase_q == PH_Q3) begin
                case (state_q)
                    ST_WRITE_BIT: begin
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = ST_WRITE_ACK;
                    end
                    ST_READ_BIT: begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_d = ST_READ_ACK;
                    end
                    ST_READ_ACK: begin
                        rd_data_d = shift_q;
                        state_d   = ST_HOLD;
                        done_d    = 1'b1;
                    end
                    ST_STOP: begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                    default: begin
                        state_d = ST_HOLD;
                        done_d  = 1'b1;
                    end
                endcase
            end
        end

        if (load_drive) begin
            drive_d = phase_drive(state_d, phase_d, shift_d[7], rd_ack_d, drive_q);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_i) begin
        // NOTE: the datapath is small, so every flop is reset and no X can reach the bus.
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            phase_q   <= PH_Q0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            rd_ack_q  <= 1'b0;
            rd_data_q <= 8'h00;
            nack_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            drive_q   <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            rd_ack_q  <= rd_ack_d;
            rd_data_q <= rd_data_d;
            nack_q    <= nack_d;
            done_q    <= done_d;
            err_q     <= err_d;
            drive_q   <= drive_d;
        end
    end

    assign cmd_ready_o = ready;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign nack_o      = nack_q;
    assign rd_data_o   = rd_data_q;
    assign busy_o      = (state_q != ST_IDLE);
    assign sda_o       = 1'b0;
    assign scl_o       = 1'b0;
    assign sda_oe      = drive_q.sda_oe;
    assign scl_oe      = drive_q.scl_oe;

endmodule

// File: tb/tb_i2c_master.sv
// Directed bench for i2c_master: pull-up bus model, byte slave and stretch slave.
module tb_i2c_master;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [2:0] cmd_i;
    logic [7:0] wr_data_i;
    logic       rd_ack_i;
    logic       done_o;
    logic [7:0] rd_data_o;
    logic       nack_o;
    logic       err_o;
    logic       busy_o;
    logic       sda_o, scl_o, sda_oe, scl_oe;
    logic       slave_sda_low = 1'b0;
    logic       slave_scl_low = 1'b0;
    logic       sda_bus, scl_bus;

    assign sda_bus = !(sda_oe || slave_sda_low);
    assign scl_bus = !(scl_oe || slave_scl_low);

    always #5 clk_i = ~clk_i;

    i2c_master #(.CLK_FREQ(40_000_000), .SCL_FREQ(400_000)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_i       (cmd_i),
        .wr_data_i   (wr_data_i),
        .rd_ack_i    (rd_ack_i),
        .done_o      (done_o),
        .rd_data_o   (rd_data_o),
        .nack_o      (nack_o),
        .err_o       (err_o),
        .busy_o      (busy_o),
        .sda_o       (sda_o),
        .scl_o       (scl_o),
        .sda_oe      (sda_oe),
        .scl_oe      (scl_oe),
        .sda_i       (sda_bus),
        .scl_i       (scl_bus)
    );

    // Bus monitor: SCL rising edges with the SDA level, START/STOP conditions.
    int   cyc = 0;
    int   rise_n = 0;
    int   rise_t [256];
    logic rise_sda [256];
    logic rise_oe [256];
    int   start_n = 0, stop_n = 0;
    int   sda_fall_t = 0, scl_fall_t = 0;
    logic prev_sda = 1'b1, prev_scl = 1'b1;

    always @(negedge clk_i) begin
        cyc      <= cyc + 1;
        prev_sda <= sda_bus;
        prev_scl <= scl_bus;
        if (scl_bus && !prev_scl && rise_n < 256) begin
            rise_t[rise_n]   <= cyc;
            rise_sda[rise_n] <= sda_bus;
            rise_oe[rise_n]  <= sda_oe;
            rise_n           <= rise_n + 1;
        end
        if (!scl_bus && prev_scl) scl_fall_t <= cyc;
        if (scl_bus && prev_scl && prev_sda && !sda_bus) begin
            start_n    <= start_n + 1;
            sda_fall_t <= cyc;
        end
        if (scl_bus && prev_scl && !prev_sda && sda_bus) stop_n <= stop_n + 1;
    end

    int checks = 0;
    int failures = 0;
    int lat, base, sb;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [2:0] c, input logic [7:0] d, input logic a);
        int n = 0;
        @(negedge clk_i);
        cmd_valid_i = 1'b1;
        cmd_i       = c;
        wr_data_i   = d;
        rd_ack_i    = a;
        while (!cmd_ready_o && n < 5000) begin
            @(negedge clk_i);
            n++;
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        cmd_i       = 3'd0;
        wr_data_i   = 8'h00;
        rd_ack_i    = 1'b0;
    endtask

    // lat = cycles from the first cycle after acceptance until done_o is seen.
    task automatic wait_done(output int l);
        l = 0;
        while (!done_o && l < 5000) begin
            @(negedge clk_i);
            l++;
        end
        check("done_seen", done_o, 1'b1);
    endtask

    task automatic wait_scl_fall();
        int n = 0;
        while (!scl_bus && n < 3000) begin @(negedge clk_i); n++; end
        while (scl_bus && n < 3000) begin @(negedge clk_i); n++; end
    endtask

    task automatic slave_tx(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            slave_sda_low = ~b[i];
            wait_scl_fall();
        end
        slave_sda_low = 1'b0;
    endtask

    // Hold SCL low for exactly 500 cycles after the master releases it in bit 1.
    task automatic stretch_once();
        int n = 0;
        while (!scl_bus && n < 3000) begin @(negedge clk_i); n++; end
        while (!scl_oe && n < 3000) begin @(negedge clk_i); n++; end
        slave_scl_low = 1'b1;
        while (scl_oe && n < 3000) begin @(negedge clk_i); n++; end
        repeat (500) @(negedge clk_i);
        #1 slave_scl_low = 1'b0;
    endtask

    function automatic logic [7:0] rise_byte(input int b);
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v = {v[6:0], rise_sda[(b + i) % 256]};
        return v;
    endfunction

    initial begin
        rst_n_i = 1'b0; cmd_valid_i = 1'b0; cmd_i = 3'd0; wr_data_i = 8'h00; rd_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("rst_ready", cmd_ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done_err_nack", {done_o, err_o, nack_o}, 3'b000);
        check("rst_rd_data", rd_data_o, 8'h00);
        check("rst_oe", {sda_oe, scl_oe}, 2'b00);
        check("rst_out_tie", {sda_o, scl_o}, 2'b00);
        rst_n_i = 1'b1;

        // Illegal / out-of-sequence commands while idle.
        base = rise_n;
        send(3'd2, 8'h55, 1'b0);
        wait_done(lat);
        check("idle_write_lat", lat, 0);
        check("idle_write_err", err_o, 1'b1);
        check("idle_write_oe", {sda_oe, scl_oe}, 2'b00);
        check("idle_write_busy", busy_o, 1'b0);
        @(negedge clk_i);
        check("err_pulse_len", err_o, 1'b0);
        check("idle_write_rises", rise_n - base, 0);
        send(3'd4, 8'h00, 1'b0);
        wait_done(lat);
        check("idle_stop_err", err_o, 1'b1);

        // START: SDA falls with SCL high, SCL falls one quarter later.
        sb = start_n;
        send(3'd0, 8'h00, 1'b0);
        wait_done(lat);
        check("start_lat", lat, 100);
        check("start_err", err_o, 1'b0);
        check("start_cond", start_n - sb, 1);
        check("start_scl_gap", scl_fall_t - sda_fall_t, 25);
        check("start_busy", busy_o, 1'b1);
        check("start_hold_oe", {sda_oe, scl_oe}, 2'b11);

        // Out-of-sequence START and illegal code in HOLD.
        send(3'd0, 8'h00, 1'b0);
        wait_done(lat);
        check("hold_start_err", err_o, 1'b1);
        check("hold_start_oe", {sda_oe, scl_oe}, 2'b11);
        send(3'd7, 8'h00, 1'b0);
        wait_done(lat);
        check("code7_err", err_o, 1'b1);

        // WRITE 0x72 with no slave.
        base = rise_n;
        send(3'd2, 8'h72, 1'b0);
        wait_done(lat);
        check("w72_lat", lat, 900);
        check("w72_rises", rise_n - base, 9);
        check("w72_bits", rise_byte(base), 8'h72);
        check("w72_ack_bit", rise_sda[(base + 8) % 256], 1'b1);
        check("w72_nack", nack_o, 1'b1);
        check("w72_bit_period0", rise_t[(base + 1) % 256] - rise_t[base % 256], 100);
        check("w72_bit_period8", rise_t[(base + 8) % 256] - rise_t[(base + 7) % 256], 100);

        // RSTART, WRITE 0xA4, STOP.
        sb = start_n;
        send(3'd1, 8'h00, 1'b0);
        wait_done(lat);
        check("rstart_lat", lat, 100);
        check("rstart_cond", start_n - sb, 1);
        check("rstart_err", err_o, 1'b0);
        base = rise_n;
        send(3'd2, 8'hA4, 1'b0);
        wait_done(lat);
        check("wa4_bits", rise_byte(base), 8'hA4);
        check("wa4_nack", nack_o, 1'b1);
        sb = stop_n;
        send(3'd4, 8'h00, 1'b0);
        wait_done(lat);
        check("stop_lat", lat, 100);
        check("stop_cond", stop_n - sb, 1);
        check("stop_busy", busy_o, 1'b0);
        check("stop_oe", {sda_oe, scl_oe}, 2'b00);

        // READ 0x5A with NACK, then 0xC3 with ACK.
        send(3'd0, 8'h00, 1'b0);
        wait_done(lat);
        base = rise_n;
        fork
            begin send(3'd3, 8'h00, 1'b0); wait_done(lat); end
            slave_tx(8'h5A);
        join
        check("r5a_lat", lat, 900);
        check("r5a_data", rd_data_o, 8'h5A);
        check("r5a_bus_bits", rise_byte(base), 8'h5A);
        check("r5a_nack_oe", rise_oe[(base + 8) % 256], 1'b0);
        check("r5a_nack_sda", rise_sda[(base + 8) % 256], 1'b1);
        base = rise_n;
        fork
            begin send(3'd3, 8'h00, 1'b1); wait_done(lat); end
            slave_tx(8'hC3);
        join
        check("rc3_data", rd_data_o, 8'hC3);
        check("rc3_ack_oe", rise_oe[(base + 8) % 256], 1'b1);
        send(3'd2, 8'h0F, 1'b0);
        wait_done(lat);
        check("rd_data_held", rd_data_o, 8'hC3);

        // WRITE 0x3C with a 500-cycle clock stretch in bit 1.
        base = rise_n;
        fork
            begin send(3'd2, 8'h3C, 1'b0); wait_done(lat); end
            stretch_once();
        join
        check("stretch_lat", lat, 1400);
        check("stretch_bits", rise_byte(base), 8'h3C);
        check("stretch_span", rise_t[(base + 2) % 256] - rise_t[base % 256], 700);
        check("stretch_last_period", rise_t[(base + 8) % 256] - rise_t[(base + 7) % 256], 100);
        send(3'd4, 8'h00, 1'b0);
        wait_done(lat);
        check("stop2_busy", busy_o, 1'b0);

        // Reset in the middle of a WRITE releases both lines at once.
        send(3'd0, 8'h00, 1'b0);
        wait_done(lat);
        sb = stop_n;
        send(3'd2, 8'h00, 1'b0);
        repeat (10) @(negedge clk_i);
        check("mid_pre_oe", {sda_oe, scl_oe}, 2'b11);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_oe", {sda_oe, scl_oe}, 2'b00);
        check("mid_rst_busy", busy_o, 1'b0);
        check("mid_rst_ready", cmd_ready_o, 1'b1);
        check("mid_rst_no_stop", stop_n - sb, 0);
        rst_n_i = 1'b1;
        send(3'd0, 8'h00, 1'b0);
        wait_done(lat);
        check("post_rst_start_lat", lat, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
